exp_scheduler: RTL

EXP_SCHEDULER -- requirements
Module: exp_scheduler

---
 rtl/exp_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/exp_scheduler.sv
// Round-robin scheduler sharing one pipelined exponent datapath among NREQ requesters.
// A {valid, index} tag pipeline rides alongside the datapath to route results back.
module exp_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 64,
  parameter int unsigned LAT  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   req_x,
  output logic [NREQ-1:0]     gnt,
  output logic                exp_vld,
  output logic [W-1:0]        exp_x,
  input  logic [W-1:0]        exp_y,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [W-1:0]        rsp_data,
  output logic [NREQ-1:0]     pending,
  output logic                idle
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]          ptr_q, ptr_d;
  logic [NREQ-1:0]        pending_q, pending_d;
  logic                   exp_vld_q, exp_vld_d;
  logic [W-1:0]           exp_x_q, exp_x_d;
  logic [IW-1:0]          iss_idx_q, iss_idx_d;
  logic [LAT-1:0]         tag_vld_q, tag_vld_d;
  logic [LAT-1:0][IW-1:0] tag_idx_q, tag_idx_d;
  logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [W-1:0]           rsp_data_q, rsp_data_d;

  logic [NREQ-1:0]        eligible;
  logic [IW:0]            cand;
  logic                   gnt_any;
  logic [IW-1:0]          gnt_idx;
  logic                   tag_exit;
  logic [IW-1:0]          exit_idx;

  // Round-robin search from ptr for the first requester without an outstanding op
  always_comb begin
    eligible = req & ~pending_q;
    cand     = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!gnt_any && eligible[cand[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
    // Grant is suppressed combinationally while reset is asserted
    if (!rst_n) begin
      gnt_any = 1'b0;
    end
    gnt = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
  end

  // Issue, tag shift, response capture and pending bookkeeping
  always_comb begin
    ptr_d       = ptr_q;
    pending_d   = pending_q;
    exp_vld_d   = gnt_any;
    exp_x_d     = exp_x_q;
    iss_idx_d   = iss_idx_q;
    tag_vld_d   = '0;
    tag_idx_d   = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;

    // Tag enters alongside exp_vld so that it leaves the last stage with exp_y
    tag_vld_d[0] = exp_vld_q;
    tag_idx_d[0] = iss_idx_q;
    for (int unsigned k = 1; k < LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_idx_d[k] = tag_idx_q[k-1];
    end

    tag_exit = tag_vld_q[LAT-1];
    exit_idx = tag_idx_q[LAT-1];

    if (tag_exit) begin
      rsp_valid_d = NREQ'(1) << exit_idx;
      rsp_data_d  = exp_y;
      pending_d   = pending_d & ~(NREQ'(1) << exit_idx);
    end

    if (gnt_any) begin
      exp_x_d   = req_x[32'(gnt_idx) * W +: W];
      iss_idx_d = gnt_idx;
      pending_d = pending_d | (NREQ'(1) << gnt_idx);
      ptr_d     = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      pending_q   <= '0;
      exp_vld_q   <= 1'b0;
      exp_x_q     <= '0;
      iss_idx_q   <= '0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      pending_q   <= pending_d;
      exp_vld_q   <= exp_vld_d;
      exp_x_q     <= exp_x_d;
      iss_idx_q   <= iss_idx_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign exp_vld   = exp_vld_q;
  assign exp_x     = exp_x_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign pending   = pending_q;
  // Idle when nothing is outstanding and nothing is travelling down the tag pipe
  assign idle      = ~|pending_q & ~|tag_vld_q & ~exp_vld_q;

endmodule
